// File: rtl/word_splitter_serial.sv
// Serialises one WORD_W word into WORD_W/SLICE_W slices, MSB- or LSB-first, one per output handshake.
// Latency: first slice valid the cycle after the word handshake; one slice/cycle when out_ready=1.
// Backpressure: slices hold while out_ready=0; in_ready follows out_ready combinationally on the last slice.
// Optional macro SPLITTER_PARITY_EN adds out_parity (even parity of out_data).
module word_splitter_serial #(
    parameter  int WORD_W     = 32,
    parameter  int SLICE_W    = 8,
    localparam int NUM_SLICES = WORD_W / SLICE_W,
    localparam int IDX_W      = $clog2(NUM_SLICES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_lsb_first,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last
`ifdef SPLITTER_PARITY_EN
    ,
    output logic               out_parity
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WORD_W-1:0]  r_word;
    logic               r_lsb;
    logic [IDX_W-1:0]   r_idx;
    logic [SLICE_W-1:0] r_data;
    logic               r_last;
    logic               r_par;

    logic               w_load;
    logic               w_adv;
    logic               w_drain;
    logic [WORD_W-1:0]  w_src_word;
    logic               w_src_lsb;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [SLICE_W-1:0] w_slice;
    logic               w_last_nxt;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == ST_IDLE) || ((r_state == ST_SEND) && r_last && out_ready);
        w_load      = in_valid && in_ready;
        w_adv       = (r_state == ST_SEND) && out_ready && !r_last;
        w_drain     = (r_state == ST_SEND) && out_ready && r_last;

        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_SEND;
            ST_SEND: if (w_drain)  w_state_nxt = in_valid ? ST_SEND : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        // A fresh capture and a plain advance share one slice-select path.
        w_src_word = w_load ? in_data : r_word;
        w_src_lsb  = w_load ? in_lsb_first : r_lsb;
        if (w_load)
            w_idx_nxt = in_lsb_first ? '0 : IDX_W'(NUM_SLICES - 1);
        else
            w_idx_nxt = r_lsb ? (r_idx + IDX_W'(1)) : (r_idx - IDX_W'(1));

        w_slice    = SLICE_W'(w_src_word >> (int'(w_idx_nxt) * SLICE_W));
        w_last_nxt = w_src_lsb ? (w_idx_nxt == IDX_W'(NUM_SLICES - 1)) : (w_idx_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word <= '0;
            r_lsb  <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
            r_par  <= 1'b0;
        end else if (w_load || w_adv) begin
            r_word <= w_src_word;
            r_lsb  <= w_src_lsb;
            r_idx  <= w_idx_nxt;
            r_data <= w_slice;
            r_last <= w_last_nxt;
            r_par  <= ^w_slice;
        end else if (w_drain) begin
            r_last <= 1'b0;
        end
    end

    assign out_valid = (r_state == ST_SEND);
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;

`ifdef SPLITTER_PARITY_EN
    assign out_parity = r_par;
`else
    logic w_par_unused;
    assign w_par_unused = r_par;
`endif

endmodule
